// File: rtl/cpu_writeback.sv
// cpu_writeback: commits stack effects, publishes top-of-stack, issues branch redirects, sticky fault.
// Optional retire counter output is enabled by defining CPU_WB_RETIRE_CNT_EN.
module cpu_writeback #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [31:0]   branch_target_4a,
    input  logic [2:0]    c__to_push_4a,
    input  logic          kill_4a,
    input  logic [31:0]   pc_4a,
    input  logic [10:0]   st__to_pop_4a,
    input  logic [34:0]   st__to_push_4a,
    output logic [34:0]   st__top0_5a,
    output logic [34:0]   st__top1_5a,
    output logic [AW:0]   st__depth_5a,
    output logic          redirect_valid_5a,
    output logic [31:0]   redirect_pc_5a,
    output logic [31:0]   pc_5a,
    output logic          halt_5a,
    output logic [1:0]    fault_code_5a
`ifdef CPU_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_cnt_5a
`endif
);
    localparam logic [2:0] UC_PUSHNONE = 3'd0;

    typedef enum logic [0:0] {StRun, StFault} state_e;
    state_e state;

    logic [34:0]   mem [DEPTH];
    logic          push, underflow, overflow, commit;
    logic [11:0]   sp_w, pop_w, nsp, wfull;
    logic [AW-1:0] widx, rd0, rd1;
    logic [34:0]   top0_d, top1_d;

    // All stack arithmetic is 12 bits wide so a pop count up to 2047 never wraps.
    always_comb begin
        push      = (c__to_push_4a != UC_PUSHNONE);
        sp_w      = 12'(st__depth_5a);
        pop_w     = {1'b0, st__to_pop_4a};
        wfull     = sp_w - pop_w;
        nsp       = wfull + {11'd0, push};
        underflow = (pop_w > sp_w);
        overflow  = !underflow && (nsp > 12'(DEPTH));
        commit    = (state == StRun) && !underflow && !overflow;
        widx      = AW'(wfull);
        rd0       = AW'(nsp - 12'd1);
        rd1       = AW'(nsp - 12'd2);
        top0_d    = '0;
        top1_d    = '0;
        // Forward the word being written so the registered tops never see a stale read.
        if (nsp >= 12'd1) begin
            top0_d = (push && (wfull == nsp - 12'd1)) ? st__to_push_4a : mem[rd0];
        end
        if (nsp >= 12'd2) begin
            top1_d = (push && (wfull == nsp - 12'd2)) ? st__to_push_4a : mem[rd1];
        end
    end

    always_ff @(posedge clk) begin
        if (commit && push) begin
            mem[widx] <= st__to_push_4a;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state             <= StRun;
            st__depth_5a      <= '0;
            st__top0_5a       <= '0;
            st__top1_5a       <= '0;
            redirect_valid_5a <= 1'b0;
            redirect_pc_5a    <= '0;
            pc_5a             <= '0;
            halt_5a           <= 1'b0;
            fault_code_5a     <= 2'b00;
`ifdef CPU_WB_RETIRE_CNT_EN
            retire_cnt_5a     <= '0;
`endif
        end else begin
            redirect_valid_5a <= 1'b0;
            if (state == StRun) begin
                if (underflow || overflow) begin
                    state         <= StFault;
                    halt_5a       <= 1'b1;
                    fault_code_5a <= underflow ? 2'b01 : 2'b10;
                end else begin
                    st__depth_5a      <= nsp[AW:0];
                    st__top0_5a       <= top0_d;
                    st__top1_5a       <= top1_d;
                    pc_5a             <= pc_4a;
                    redirect_valid_5a <= kill_4a;
                    if (kill_4a) begin
                        redirect_pc_5a <= branch_target_4a;
                    end
`ifdef CPU_WB_RETIRE_CNT_EN
                    if (push || (st__to_pop_4a != 11'd0) || kill_4a) begin
                        retire_cnt_5a <= retire_cnt_5a + 32'd1;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: a DEPTH=256 and a DEPTH=4 instance share stimulus and are checked
// against an array-based stack model, plus a constant-expectation vector table.
module tb_cpu_writeback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic [31:0] target, pc;
    logic [2:0]  cpush;
    logic        kill;
    logic [10:0] pop;
    logic [34:0] word;

    logic [34:0] a_t0, a_t1, b_t0, b_t1;
    logic [8:0]  a_dep;
    logic [2:0]  b_dep;
    logic        a_rv, b_rv, a_h, b_h;
    logic [31:0] a_rpc, b_rpc, a_pc, b_pc;
    logic [1:0]  a_code, b_code;
`ifdef CPU_WB_RETIRE_CNT_EN
    logic [31:0] a_ret, b_ret;
`endif

    cpu_writeback #(.DEPTH(256), .AW(8)) u_big (
        .clk(clk), .rst_b(rst_b), .branch_target_4a(target), .c__to_push_4a(cpush),
        .kill_4a(kill), .pc_4a(pc), .st__to_pop_4a(pop), .st__to_push_4a(word),
        .st__top0_5a(a_t0), .st__top1_5a(a_t1), .st__depth_5a(a_dep),
        .redirect_valid_5a(a_rv), .redirect_pc_5a(a_rpc), .pc_5a(a_pc), .halt_5a(a_h),
        .fault_code_5a(a_code)
`ifdef CPU_WB_RETIRE_CNT_EN
        , .retire_cnt_5a(a_ret)
`endif
    );

    cpu_writeback #(.DEPTH(4), .AW(2)) u_small (
        .clk(clk), .rst_b(rst_b), .branch_target_4a(target), .c__to_push_4a(cpush),
        .kill_4a(kill), .pc_4a(pc), .st__to_pop_4a(pop), .st__to_push_4a(word),
        .st__top0_5a(b_t0), .st__top1_5a(b_t1), .st__depth_5a(b_dep),
        .redirect_valid_5a(b_rv), .redirect_pc_5a(b_rpc), .pc_5a(b_pc), .halt_5a(b_h),
        .fault_code_5a(b_code)
`ifdef CPU_WB_RETIRE_CNT_EN
        , .retire_cnt_5a(b_ret)
`endif
    );

    int ncmp = 0;
    int nfail = 0;

    // Reference model: one stack per instance, indexed 0 (DEPTH 256) and 1 (DEPTH 4).
    logic [34:0] mstk [2][2048];
    int          msp [2];
    logic        mhalt [2];
    logic [1:0]  mcode [2];
    logic [31:0] mpc [2];
    logic [31:0] mrpc [2];
    logic        mrv [2];
    logic [31:0] mret [2];

    function automatic int mdepth(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic logic [34:0] exp_top(input int k, input int n);
        return (msp[k] >= n) ? mstk[k][msp[k] - n] : 35'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            msp[k] = 0; mhalt[k] = 1'b0; mcode[k] = 2'b00; mpc[k] = '0;
            mrpc[k] = '0; mrv[k] = 1'b0; mret[k] = '0;
        end
    endtask

    task automatic model_step();
        int  np;
        int  ps;
        for (int k = 0; k < 2; k++) begin
            ps = (cpush != 3'd0) ? 1 : 0;
            np = int'(pop);
            mrv[k] = 1'b0;
            if (mhalt[k]) continue;
            if (np > msp[k]) begin
                mhalt[k] = 1'b1; mcode[k] = 2'b01;
            end else if (msp[k] - np + ps > mdepth(k)) begin
                mhalt[k] = 1'b1; mcode[k] = 2'b10;
            end else begin
                if (ps == 1) mstk[k][msp[k] - np] = word;
                msp[k] = msp[k] - np + ps;
                mpc[k] = pc;
                if (kill) begin
                    mrv[k] = 1'b1; mrpc[k] = target;
                end
                if (ps == 1 || np != 0 || kill) mret[k] = mret[k] + 32'd1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.top0", 64'(a_t0), 64'(exp_top(0, 1)));
        chk("a.top1", 64'(a_t1), 64'(exp_top(0, 2)));
        chk("a.depth", 64'(a_dep), 64'(msp[0]));
        chk("a.rv", 64'(a_rv), 64'(mrv[0]));
        chk("a.rpc", 64'(a_rpc), 64'(mrpc[0]));
        chk("a.pc", 64'(a_pc), 64'(mpc[0]));
        chk("a.halt", 64'(a_h), 64'(mhalt[0]));
        chk("a.code", 64'(a_code), 64'(mcode[0]));
        chk("b.top0", 64'(b_t0), 64'(exp_top(1, 1)));
        chk("b.top1", 64'(b_t1), 64'(exp_top(1, 2)));
        chk("b.depth", 64'(b_dep), 64'(msp[1]));
        chk("b.rv", 64'(b_rv), 64'(mrv[1]));
        chk("b.rpc", 64'(b_rpc), 64'(mrpc[1]));
        chk("b.pc", 64'(b_pc), 64'(mpc[1]));
        chk("b.halt", 64'(b_h), 64'(mhalt[1]));
        chk("b.code", 64'(b_code), 64'(mcode[1]));
`ifdef CPU_WB_RETIRE_CNT_EN
        chk("a.retire", 64'(a_ret), 64'(mret[0]));
        chk("b.retire", 64'(b_ret), 64'(mret[1]));
`endif
    endtask

    // Inputs change on the falling edge; the model samples them at the rising edge.
    task automatic step(input logic [10:0] p, input logic [2:0] c, input logic [34:0] w,
                        input logic k, input logic [31:0] tg, input logic [31:0] pcv);
        pop = p; cpush = c; word = w; kill = k; target = tg; pc = pcv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asserted mid-cycle to exercise the asynchronous clear.
    task automatic do_reset();
        pop = '0; cpush = '0; word = '0; kill = 1'b0; target = '0; pc = '0;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_b = 1'b1;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [10:0] p;
        logic [2:0]  c;
        logic [34:0] w;
        logic        k;
        logic [31:0] tg;
        logic [31:0] pcv;
        logic [8:0]  sp;
        logic [34:0] t0;
        logic [34:0] t1;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc5;
        logic        h;
        logic [1:0]  code;
    } vec_t;

    localparam logic [34:0] WA = 35'h1_0000_000A;
    localparam logic [34:0] WB = 35'h1_0000_000B;
    localparam logic [34:0] WC = 35'h1_0000_000C;
    localparam logic [34:0] W5 = 35'h1_0000_0005;

    vec_t tbl [10];

    initial begin
        logic [10:0] p;
        logic [2:0]  c;
        rst_b = 1'b0;
        pop = '0; cpush = '0; word = '0; kill = 1'b0; target = '0; pc = '0;
        @(negedge clk);
        do_reset();

        //        pop c  word k  target      pc          sp t0  t1  rv rpc        pc5        h code
        tbl[0] = '{0, 1, WA, 0, 32'h0,   32'h10, 1, WA, 0,  0, 32'h0,   32'h10, 0, 0};
        tbl[1] = '{0, 1, WB, 0, 32'h0,   32'h14, 2, WB, WA, 0, 32'h0,   32'h14, 0, 0};
        tbl[2] = '{0, 1, WC, 0, 32'h0,   32'h18, 3, WC, WB, 0, 32'h0,   32'h18, 0, 0};
        tbl[3] = '{2, 3, W5, 0, 32'h0,   32'h1c, 2, W5, WA, 0, 32'h0,   32'h1c, 0, 0};
        tbl[4] = '{0, 0, 0,  1, 32'h100, 32'h20, 2, W5, WA, 1, 32'h100, 32'h20, 0, 0};
        tbl[5] = '{0, 0, 0,  0, 32'h0,   32'h24, 2, W5, WA, 0, 32'h100, 32'h24, 0, 0};
        tbl[6] = '{1, 0, 0,  0, 32'h0,   32'h28, 1, WA, 0,  0, 32'h100, 32'h28, 0, 0};
        tbl[7] = '{2, 0, 0,  0, 32'h0,   32'h2c, 1, WA, 0,  0, 32'h100, 32'h28, 1, 1};
        tbl[8] = '{0, 7, WC, 1, 32'h200, 32'h30, 1, WA, 0,  0, 32'h100, 32'h28, 1, 1};
        tbl[9] = '{0, 0, 0,  1, 32'h300, 32'h34, 1, WA, 0,  0, 32'h100, 32'h28, 1, 1};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].p, tbl[i].c, tbl[i].w, tbl[i].k, tbl[i].tg, tbl[i].pcv);
            chk("vec.sp", 64'(a_dep), 64'(tbl[i].sp));
            chk("vec.top0", 64'(a_t0), 64'(tbl[i].t0));
            chk("vec.top1", 64'(a_t1), 64'(tbl[i].t1));
            chk("vec.rv", 64'(a_rv), 64'(tbl[i].rv));
            chk("vec.rpc", 64'(a_rpc), 64'(tbl[i].rpc));
            chk("vec.pc", 64'(a_pc), 64'(tbl[i].pc5));
            chk("vec.halt", 64'(a_h), 64'(tbl[i].h));
            chk("vec.code", 64'(a_code), 64'(tbl[i].code));
        end

        do_reset();
        chk("rst.halt", 64'(a_h), 64'd0);
        chk("rst.depth", 64'(a_dep), 64'd0);
        chk("rst.rpc", 64'(a_rpc), 64'd0);

        // DEPTH=4: fill, then a push with no pop must overflow on the small instance only.
        for (int i = 0; i < 4; i++) step(0, 1, 35'h2_0000_0000 + 35'(i), 0, 0, 32'h100 + 32'(4 * i));
        step(0, 1, 35'h3_0000_0000, 1, 32'h400, 32'h200);
        chk("ovf.code", 64'(b_code), 64'd2);
        chk("ovf.halt", 64'(b_h), 64'd1);
        chk("ovf.depth", 64'(b_dep), 64'd4);
        chk("ovf.pc", 64'(b_pc), 64'h10c);
        chk("ovf.rv", 64'(b_rv), 64'd0);
        chk("ovf.big_depth", 64'(a_dep), 64'd5);

        // Full stack, pop 1 + push is a legal replace.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 35'h2_0000_0000 + 35'(i), 0, 0, 32'h100 + 32'(4 * i));
        step(1, 2, 35'h7_1234_5678, 0, 0, 32'h300);
        chk("repl.halt", 64'(b_h), 64'd0);
        chk("repl.depth", 64'(b_dep), 64'd4);
        chk("repl.top0", 64'(b_t0), 64'h7_1234_5678);
        chk("repl.top1", 64'(b_t1), 64'h2_0000_0002);
        step(11'd2047, 0, 0, 0, 0, 32'h304);
        chk("bigpop.code", 64'(b_code), 64'd1);
        chk("bigpop.a_code", 64'(a_code), 64'd1);
        chk("bigpop.depth", 64'(a_dep), 64'd4);

`ifdef CPU_WB_RETIRE_CNT_EN
        do_reset();
        step(0, 1, WA, 0, 0, 32'h10);
        step(0, 0, 0, 0, 0, 32'h14);
        step(0, 1, WB, 0, 0, 32'h18);
        step(1, 0, 0, 0, 0, 32'h1c);
        step(0, 0, 0, 0, 0, 32'h20);
        step(0, 0, 0, 1, 32'h80, 32'h24);
        step(0, 0, 0, 0, 0, 32'h28);
        step(1, 4, WC, 0, 0, 32'h2c);
        chk("ret.count", 64'(a_ret), 64'd5);
        step(11'd9, 0, 0, 0, 0, 32'h30);
        step(0, 1, WA, 1, 32'h90, 32'h34);
        chk("ret.frozen", 64'(a_ret), 64'd5);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            p = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047))
                                            : 11'($urandom_range(0, 2));
            c = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(1, 7)) : 3'd0;
            step(p, c, 35'({32'($urandom_range(0, 7)), 32'($urandom)}),
                 ($urandom_range(0, 4) == 0), $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
